// File: rtl/nav_pkg.sv
// Shared navigation definitions: sequencer phases, motor codes, executor states.
package nav_pkg;

  localparam logic [1:0] RUN_INI = 2'b00;
  localparam logic [1:0] RUN_EXC = 2'b01;
  localparam logic [1:0] RUN_COM = 2'b10;
  localparam logic [1:0] RUN_ERR = 2'b11;

  localparam logic [4:0] TURN_RIGHT = 5'b01111;
  localparam logic [4:0] TURN_LEFT  = 5'b01110;
  localparam logic [4:0] STRAIGHT   = 5'b01100;
  localparam logic [4:0] STOP       = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  function automatic logic is_valid_cmd(input logic [4:0] cmd);
    return (cmd == TURN_RIGHT) || (cmd == TURN_LEFT) || (cmd == STRAIGHT);
  endfunction

endpackage

// File: rtl/hit_confirm.sv
// Counts consecutive hit samples; done flags the sample that reaches CONFIRM.
module hit_confirm #(
  parameter int CONFIRM = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic strobe,
  input  logic hit,
  input  logic clear,
  output logic done
);

  localparam int CW = $clog2(CONFIRM + 1);

  logic [CW-1:0] r_count;

  // done is combinational so the completing sample moves the FSM on its own edge
  assign done = strobe & hit & ~clear & (r_count >= CW'(CONFIRM - 1));

  // consecutive-hit counter: miss clears, idle cycles hold, saturates at CONFIRM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (strobe) begin
      if (!hit) begin
        r_count <= '0;
      end else if (r_count != CW'(CONFIRM)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motion_executor.sv
// Executes one move per EXC entry: drives the motor, confirms arrival from
// sensor samples, and reports completion or failure (timeout / bad command).
module motion_executor
  import nav_pkg::*;
#(
  parameter int CONFIRM = 3,
  parameter int TOL     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] RUN_FLAG,
  input  logic [4:0] COMMAND,
  input  logic [7:0] PATH,
  input  logic [7:0] COMPARE_DISTANCE,
  input  logic [7:0] DISTANCE_FRONT,
  input  logic [7:0] DISTANCE_SIDE_FRONT,
  input  logic       DIST_VALID,
  output logic       NEXT_FLAG,
  output logic [4:0] MOTOR_CMD,
  output logic       BUSY,
  output logic       ERR_FLAG
);

  state_t      r_state;
  logic [1:0]  r_prev_flag;
  logic [4:0]  r_cmd;
  logic [7:0]  r_path;
  logic [7:0]  r_cmp;
  logic [11:0] r_samples;
  logic        r_next_flag;
  logic        r_busy;
  logic        r_err;
  logic [4:0]  r_motor;

  logic        w_start;
  logic [8:0]  w_side_diff;
  logic        w_hit;
  logic        w_strobe;
  logic        w_clear;
  logic        w_done;
  logic [11:0] w_samples_inc;
  logic        w_timeout;

  assign w_start = (RUN_FLAG == RUN_EXC) && (r_prev_flag != RUN_EXC);

  // 9-bit magnitude so a side reading far below the target cannot wrap into a hit
  assign w_side_diff = (DISTANCE_SIDE_FRONT >= r_cmp)
                     ? ({1'b0, DISTANCE_SIDE_FRONT} - {1'b0, r_cmp})
                     : ({1'b0, r_cmp} - {1'b0, DISTANCE_SIDE_FRONT});

  assign w_hit = (r_cmd == STRAIGHT) ? (DISTANCE_FRONT <= r_cmp)
                                     : (w_side_diff <= 9'(TOL));

  assign w_strobe      = DIST_VALID && (r_state == ST_RUN);
  assign w_clear       = (r_state != ST_RUN);
  assign w_samples_inc = r_samples + 12'd1;
  assign w_timeout     = (r_path != 8'd0) && DIST_VALID
                       && (w_samples_inc == {r_path, 4'b0000});

  hit_confirm #(.CONFIRM(CONFIRM)) u_hit_confirm (
    .CLK    (CLK),
    .RST    (RST),
    .strobe (w_strobe),
    .hit    (w_hit),
    .clear  (w_clear),
    .done   (w_done)
  );

  // previous RUN_FLAG for EXC entry detection; reset to INI so EXC at release starts a move
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_prev_flag <= RUN_INI;
    else     r_prev_flag <= RUN_FLAG;
  end

  // move FSM with outputs registered alongside the state they belong to
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_path      <= '0;
      r_cmp       <= '0;
      r_samples   <= '0;
      r_next_flag <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_motor     <= STOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cmd     <= COMMAND;
            r_path    <= PATH;
            r_cmp     <= COMPARE_DISTANCE;
            r_samples <= '0;
            if (is_valid_cmd(COMMAND)) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_motor <= COMMAND;
            end else begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
              r_motor <= STOP;
            end
          end
        end
        ST_RUN: begin
          if (RUN_FLAG != RUN_EXC) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_motor <= STOP;
          end else if (w_done) begin
            // completion is tested before timeout so it wins a same-sample tie
            r_state     <= ST_DONE;
            r_next_flag <= 1'b1;
            r_busy      <= 1'b0;
            r_motor     <= STOP;
          end else if (w_timeout) begin
            r_state <= ST_ERROR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_motor <= STOP;
          end else if (DIST_VALID) begin
            r_samples <= w_samples_inc;
          end
        end
        ST_DONE: begin
          if (RUN_FLAG != RUN_EXC) begin
            r_state     <= ST_IDLE;
            r_next_flag <= 1'b0;
          end
        end
        ST_ERROR: begin
          if (RUN_FLAG == RUN_INI) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_motor <= STOP;
        end
      endcase
    end
  end

  assign NEXT_FLAG = r_next_flag;
  assign MOTOR_CMD = r_motor;
  assign BUSY      = r_busy;
  assign ERR_FLAG  = r_err;

endmodule

// File: tb/tb_motion_executor.sv
// Directed bench for motion_executor with a queue-based expected-value scoreboard.
module tb_motion_executor;
  import nav_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] RUN_FLAG;
  logic [4:0] COMMAND;
  logic [7:0] PATH;
  logic [7:0] COMPARE_DISTANCE;
  logic [7:0] DISTANCE_FRONT;
  logic [7:0] DISTANCE_SIDE_FRONT;
  logic       DIST_VALID;
  logic       NEXT_FLAG;
  logic [4:0] MOTOR_CMD;
  logic       BUSY;
  logic       ERR_FLAG;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam int S_STOP = 8;
  localparam int S_STR  = 12;
  localparam int S_LEFT = 14;

  motion_executor #(.CONFIRM(3), .TOL(2)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .RUN_FLAG            (RUN_FLAG),
    .COMMAND             (COMMAND),
    .PATH                (PATH),
    .COMPARE_DISTANCE    (COMPARE_DISTANCE),
    .DISTANCE_FRONT      (DISTANCE_FRONT),
    .DISTANCE_SIDE_FRONT (DISTANCE_SIDE_FRONT),
    .DIST_VALID          (DIST_VALID),
    .NEXT_FLAG           (NEXT_FLAG),
    .MOTOR_CMD           (MOTOR_CMD),
    .BUSY                (BUSY),
    .ERR_FLAG            (ERR_FLAG)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(string t, logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  task automatic expect_out(string t, int nf, int b, int er, int mc);
    push_exp({t, ".next"}, 32'(nf));
    push_exp({t, ".busy"}, 32'(b));
    push_exp({t, ".err"},  32'(er));
    push_exp({t, ".motor"}, 32'(mc));
  endtask

  task automatic check_out();
    pop_check(32'(NEXT_FLAG));
    pop_check(32'(BUSY));
    pop_check(32'(ERR_FLAG));
    pop_check(32'(MOTOR_CMD));
  endtask

  task automatic step_chk(string t, int nf, int b, int er, int mc);
    expect_out(t, nf, b, er, mc);
    tick();
    check_out();
  endtask

  task automatic sample(string t, logic [7:0] f, logic [7:0] s,
                        int nf, int b, int er, int mc);
    DISTANCE_FRONT      = f;
    DISTANCE_SIDE_FRONT = s;
    DIST_VALID          = 1'b1;
    step_chk(t, nf, b, er, mc);
    DIST_VALID          = 1'b0;
  endtask

  task automatic start_move(string t, logic [4:0] cmd, logic [7:0] path,
                            logic [7:0] cmp, int b, int er, int mc);
    COMMAND          = cmd;
    PATH             = path;
    COMPARE_DISTANCE = cmp;
    RUN_FLAG         = RUN_EXC;
    step_chk(t, 0, b, er, mc);
    COMMAND          = 5'b10101;
    PATH             = 8'd0;
    COMPARE_DISTANCE = 8'd200;
  endtask

  initial begin
    automatic logic [7:0] turn_s[7] = '{53, 52, 49, 60, 51, 50, 48};

    RST = 1'b1;
    RUN_FLAG = RUN_INI;
    COMMAND = 5'b0;
    PATH = 8'd0;
    COMPARE_DISTANCE = 8'd0;
    DISTANCE_FRONT = 8'd0;
    DISTANCE_SIDE_FRONT = 8'd0;
    DIST_VALID = 1'b0;

    expect_out("reset", 0, 0, 0, S_STOP);
    #2;
    check_out();
    tick();
    tick();
    RST = 1'b0;
    step_chk("idle_ini", 0, 0, 0, S_STOP);

    // straight move: 40 misses, 12/11/10 confirm
    start_move("str_start", STRAIGHT, 8'd4, 8'd12, 1, 0, S_STR);
    sample("str_s1", 8'd40, 8'd0, 0, 1, 0, S_STR);
    sample("str_s2", 8'd12, 8'd0, 0, 1, 0, S_STR);
    sample("str_s3", 8'd11, 8'd0, 0, 1, 0, S_STR);
    step_chk("str_gap", 0, 1, 0, S_STR);
    sample("str_s4", 8'd10, 8'd0, 1, 0, 0, S_STOP);

    // EXC held after DONE must not restart
    COMMAND = STRAIGHT;
    for (int i = 0; i < 100; i++)
      step_chk($sformatf("hold_done%0d", i), 1, 0, 0, S_STOP);
    RUN_FLAG = RUN_COM;
    step_chk("done_exit", 0, 0, 0, S_STOP);

    // turn-left move, 60 breaks the run of hits
    start_move("left_start", TURN_LEFT, 8'd0, 8'd50, 1, 0, S_LEFT);
    for (int i = 0; i < 7; i++)
      sample($sformatf("left_s%0d", i + 1), 8'd0, turn_s[i],
             (i == 6) ? 1 : 0, (i == 6) ? 0 : 1, 0, (i == 6) ? S_STOP : S_LEFT);
    RUN_FLAG = RUN_INI;
    step_chk("left_exit", 0, 0, 0, S_STOP);

    // timeout after 16 samples with PATH=1
    start_move("to_start", STRAIGHT, 8'd1, 8'd12, 1, 0, S_STR);
    for (int i = 0; i < 15; i++)
      sample($sformatf("to_s%0d", i + 1), 8'd100, 8'd0, 0, 1, 0, S_STR);
    sample("to_s16", 8'd100, 8'd0, 0, 0, 1, S_STOP);
    RUN_FLAG = RUN_COM;
    step_chk("err_hold_com", 0, 0, 1, S_STOP);
    RUN_FLAG = RUN_INI;
    step_chk("err_clear", 0, 0, 0, S_STOP);

    // completion and timeout on the same sample: completion wins
    start_move("tie_start", STRAIGHT, 8'd1, 8'd12, 1, 0, S_STR);
    for (int i = 0; i < 13; i++)
      sample($sformatf("tie_s%0d", i + 1), 8'd100, 8'd0, 0, 1, 0, S_STR);
    sample("tie_s14", 8'd5, 8'd0, 0, 1, 0, S_STR);
    sample("tie_s15", 8'd5, 8'd0, 0, 1, 0, S_STR);
    sample("tie_s16", 8'd12, 8'd0, 1, 0, 0, S_STOP);
    RUN_FLAG = RUN_INI;
    step_chk("tie_exit", 0, 0, 0, S_STOP);

    // invalid command goes straight to ERROR, motor never moves
    start_move("bad_cmd", 5'b00000, 8'd4, 8'd12, 0, 1, S_STOP);
    step_chk("bad_hold", 0, 0, 1, S_STOP);
    RUN_FLAG = RUN_INI;
    step_chk("bad_clear", 0, 0, 0, S_STOP);

    // abort after 5 samples
    start_move("ab_start", STRAIGHT, 8'd0, 8'd12, 1, 0, S_STR);
    sample("ab_s1", 8'd100, 8'd0, 0, 1, 0, S_STR);
    sample("ab_s2", 8'd100, 8'd0, 0, 1, 0, S_STR);
    sample("ab_s3", 8'd100, 8'd0, 0, 1, 0, S_STR);
    sample("ab_s4", 8'd10, 8'd0, 0, 1, 0, S_STR);
    sample("ab_s5", 8'd10, 8'd0, 0, 1, 0, S_STR);
    RUN_FLAG = RUN_INI;
    step_chk("ab_idle", 0, 0, 0, S_STOP);
    step_chk("ab_after", 0, 0, 0, S_STOP);

    // reset mid-move stops the motor without a clock edge
    start_move("rst_start", STRAIGHT, 8'd0, 8'd12, 1, 0, S_STR);
    #2;
    RST = 1'b1;
    expect_out("rst_async", 0, 0, 0, S_STOP);
    #1;
    check_out();
    tick();
    RST = 1'b0;
    COMMAND = STRAIGHT;
    COMPARE_DISTANCE = 8'd12;
    step_chk("exc_at_release", 0, 1, 0, S_STR);
    RUN_FLAG = RUN_INI;
    step_chk("final_idle", 0, 0, 0, S_STOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
